// File: rtl/iomem_rr_scheduler_pkg.sv
// Shared types and constants for the iomem round-robin scheduler.
//   sched_state_e : scheduler FSM states
//   sched_req_t   : one requester's block-transfer request
//   REQ_*         : fixed requester slot assignment
package iomem_rr_scheduler_pkg;

    localparam int unsigned SchedXlen    = 32;
    localparam int unsigned SchedBlkSize = 128;
    localparam int unsigned SchedStrbW   = 16;

    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;
    localparam int unsigned REQ_DBG    = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } sched_state_e;

    typedef struct packed {
        logic                    valid;
        logic [SchedXlen-1:0]    addr;
        logic [SchedStrbW-1:0]   wstrb;
        logic [SchedBlkSize-1:0] wdata;
    } sched_req_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iomem_rr_scheduler_if.sv
// Downstream iomem port bundle.
//   master : scheduler side (drives valid/addr/wstrb/wdata, receives ready/rdata)
//   slave  : memory side
interface iomem_rr_scheduler_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BLK_SIZE = 128
);
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic [15:0]         wstrb;
    logic [BLK_SIZE-1:0] wdata;
    logic [BLK_SIZE-1:0] rdata;

    modport master (
        output valid, addr, wstrb, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wstrb, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/iomem_rr_scheduler_rr_pick.sv
// Rotate-priority encoder: finds the first set bit of req_i searching from
// ptr_i upward with wrap-around.
//   req_i   : request vector
//   ptr_i   : starting index (must be < NUM_REQ)
//   found_o : any request set
//   idx_o   : winning index (0 when nothing found)
module iomem_rr_scheduler_rr_pick
    import iomem_rr_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IdxW   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               found_o,
    output logic [IdxW-1:0]    idx_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [IdxW:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NUM_REQ)) begin
                cand = cand - (IdxW+1)'(NUM_REQ);
            end
            if (!found_o && |(req_i & (NUM_REQ'(1) << cand))) begin
                found_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/iomem_rr_scheduler.sv
// Round-robin scheduler sharing one iomem port among NUM_REQ block requesters
// (0 = icache, 1 = dcache, 2 = debug/DMA). One transaction at a time; the
// downstream request is held from latched registers until ready, then read
// data is returned registered with a one-cycle one-hot completion pulse.
// Optional watchdog: define IOMEM_WATCHDOG_EN to abort BUSY after TIMEOUT_CYC
// cycles without ready (res_err_o=1, res_rdata_o=0).
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   req_*_i       : per-requester level request, address, strobes, write data
//   res_valid_o   : one-hot completion pulse
//   res_rdata_o   : registered read data
//   res_err_o     : completion was a watchdog abort
//   iomem         : downstream port (master modport)
//   busy_o        : scheduler not idle
//   grant_o       : requester currently owning the port
module iomem_rr_scheduler
    import iomem_rr_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned XLEN        = SchedXlen,
    parameter int unsigned BLK_SIZE    = SchedBlkSize,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned IdxW       = idx_width(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_addr_i,
    input  logic [NUM_REQ-1:0][15:0]           req_wstrb_i,
    input  logic [NUM_REQ-1:0][BLK_SIZE-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                 res_valid_o,
    output logic [BLK_SIZE-1:0]                res_rdata_o,
    output logic                               res_err_o,
    iomem_rr_scheduler_if.master               iomem,
    output logic                               busy_o,
    output logic [IdxW-1:0]                    grant_o
);

    if (TIMEOUT_CYC < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 2");
    end

    sched_state_e        state_q, state_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [XLEN-1:0]     addr_q;
    logic [15:0]         wstrb_q;
    logic [BLK_SIZE-1:0] wdata_q;
    logic [BLK_SIZE-1:0] rdata_q;
    logic                latch_en;
    logic                cap_en;
    logic                pick_found;
    logic [IdxW-1:0]     pick_idx;

    iomem_rr_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

`ifdef IOMEM_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    logic [CntW-1:0] wd_cnt_q;
    logic            timeout_hit;
    logic            err_q;

    // Ready in the same cycle as expiry takes the normal-completion path.
    assign timeout_hit = (state_q == StBusy) && !iomem.ready &&
                         (wd_cnt_q == CntW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        latch_en = 1'b0;
        cap_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    latch_en = 1'b1;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (iomem.ready) begin
                    cap_en  = 1'b1;
                    state_d = StDone;
                end
`ifdef IOMEM_WATCHDOG_EN
                else if (timeout_hit) begin
                    cap_en  = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                rr_ptr_d = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (latch_en) begin
                addr_q  <= req_addr_i[pick_idx];
                wstrb_q <= req_wstrb_i[pick_idx];
                wdata_q <= req_wdata_i[pick_idx];
            end
            if (cap_en) begin
`ifdef IOMEM_WATCHDOG_EN
                rdata_q <= timeout_hit ? '0 : iomem.rdata;
`else
                rdata_q <= iomem.rdata;
`endif
            end
        end
    end

`ifdef IOMEM_WATCHDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (latch_en) begin
                wd_cnt_q <= '0;
            end else if (state_q == StBusy && !iomem.ready) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (cap_en) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign res_err_o = err_q && (state_q == StDone);
`else
    assign res_err_o = 1'b0;
`endif

    assign iomem.valid = (state_q == StBusy);
    assign iomem.addr  = addr_q;
    assign iomem.wstrb = wstrb_q;
    assign iomem.wdata = wdata_q;
    assign res_valid_o = (state_q == StDone) ? (NUM_REQ'(1) << grant_q) : '0;
    assign res_rdata_o = rdata_q;
    assign busy_o      = (state_q != StIdle);
    assign grant_o     = grant_q;

endmodule

// File: doc/iomem_rr_scheduler.md
Name: iomem_rr_scheduler

Overview:
- Round-robin scheduler sharing the single external iomem port among NUM_REQ block-transfer requesters: icache refill, dcache refill/writeback and a debug/DMA port.
- Sits between the cache request structs and the cpu top-level iomem pins.
- Serializes one transaction at a time.
- Holds the downstream request stable until iomem_ready_i, then returns registered read data to the granted requester.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = icache, 1 = dcache, 2 = debug/DMA.
- XLEN, 32, address width (from tcore_param).
- BLK_SIZE, 128, data block width in bits (from tcore_param).
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  level request per requester, held until its res_valid_o pulse.
- req_addr_i  in  NUM_REQ x XLEN  block-aligned address per requester.
- req_wstrb_i  in  NUM_REQ x 16  byte strobes; all-zero means read.
- req_wdata_i  in  NUM_REQ x BLK_SIZE  write block per requester.
- res_valid_o  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- res_rdata_o  out  BLK_SIZE  registered read data, valid while any res_valid_o bit is set.
- res_err_o  out  1  completion was a watchdog abort; always 0 without the optional feature.
- iomem_valid_o  out  1  downstream request valid.
- iomem_ready_i  in  1  downstream completion.
- iomem_addr_o  out  XLEN  downstream address.
- iomem_wstrb_o  out  16  downstream strobes.
- iomem_wdata_o  out  BLK_SIZE  downstream write data.
- iomem_rdata_i  in  BLK_SIZE  downstream read data, sampled when iomem_ready_i=1.
- busy_o  out  1  state != IDLE.
- grant_o  out  $clog2(NUM_REQ)  index currently owning the port.

Behaviour:
- Reset values (asynchronous):
  - all outputs 0; state=IDLE; rr_ptr=0; grant_o=0.
  - addr/wstrb/wdata registers cleared.
  - watchdog counter 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - Latch that requester's addr/wstrb/wdata into the output registers; set grant_o; go to BUSY.
  - No requests: stay in IDLE, outputs unchanged.
- BUSY:
  - iomem_valid_o=1; addr/wstrb/wdata held stable from the latched registers, immune to input changes.
  - On iomem_ready_i=1: capture iomem_rdata_i into res_rdata_o; go to DONE.
- DONE:
  - res_valid_o[grant_o]=1 for exactly one cycle; iomem_valid_o=0.
  - rr_ptr <= grant_o+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE. Requests are not sampled in DONE.
- Latency:
  - Request seen at cycle 0 in IDLE -> iomem_valid_o=1 at cycle 1.
  - iomem_ready_i at cycle k -> res_valid_o at cycle k+1.
  - Next grant's iomem_valid_o at cycle k+3 at the earliest.
- Requester obligations: deassert or change req_valid_i in the cycle after its res_valid_o pulse. A request still high at IDLE is treated as a new transaction.
- Fairness: a requester that stays asserted is served within NUM_REQ transactions.
- A req_valid_i dropped during BUSY does not abort the transaction; the result is still pulsed.
- iomem_ready_i outside BUSY is ignored.
- A write (wstrb != 0) also pulses res_valid_o. res_rdata_o is then whatever iomem_rdata_i carried and is don't-care to the requester.
- Reset asserted mid-BUSY: iomem_valid_o drops immediately (asynchronous) and no res_valid_o is issued. The downstream memory must tolerate the abandoned request.

Optional Feature:
- Macro: IOMEM_WATCHDOG_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYC-1 with no ready: go to DONE with res_err_o=1 alongside the res_valid_o pulse, and res_rdata_o forced to 0.
  - Ready arriving in the same cycle as the timeout wins: normal completion, res_err_o=0.
- Not defined: no counter is built; BUSY waits indefinitely; res_err_o tied 0.

Decomposition:
- tcore_param gains:
  - sched_state_e {IDLE, BUSY, DONE}.
  - typedef sched_req_t {valid, addr, wstrb, wdata}.
  - constants REQ_ICACHE=0, REQ_DCACHE=1, REQ_DBG=2.
- Sub-module rr_pick: combinational rotate-priority encoder taking (req vector, rr_ptr) and returning (found, index); reusable by other arbiters.

Test Plan:
- Single read: req_valid_i=3'b001, addr 0x8000_0040, ready 4 cycles after iomem_valid_o rises with rdata 0xDEADBEEF_... -> res_valid_o=3'b001 one cycle after ready with matching data; busy_o low one cycle later.
- Round-robin: all three requesters held high, ready after 1 cycle each -> grant order 0,1,2,0; each res_valid_o bit pulses once per round.
- Write: req 1 with wstrb=16'hFFFF, wdata pattern A5 -> iomem_wstrb_o/wdata_o stable across 10 BUSY cycles even when req_wdata_i changes; single res_valid_o[1] pulse.
- Contention after completion: req 0 completes while req 1 is already waiting and req 0 re-requests -> req 1 granted next.
- Reset mid-BUSY: rst_i asserted during cycle 3 of BUSY -> iomem_valid_o=0 same cycle, no res_valid_o; after release rr_ptr=0.
- With IOMEM_WATCHDOG_EN and TIMEOUT_CYC=8: ready never asserted -> res_valid_o pulse with res_err_o=1 and res_rdata_o=0 eight cycles after BUSY entry; ready arriving on cycle 8 -> res_err_o=0.
